fetch_stage: RTL and testbench

Instruction fetch stage feeding the control unit and register file. Holds the PC and issues word addresses to a synchronous instruction memory. Captures the returned instruction into an IF/ID register with a valid bit, and splits it into the fields consumed downstream: the 11-bit opcode for control, plus register and immediate fields. Supports pipeline stall, branch redirect/flush and a retired-fetch counter.

---
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_stage.sv | 59 +++++
 tb/tb_fetch_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: control, IMEM and IF/ID signals of the fetch stage
interface fetch_if #(parameter int ADDR_W = 8);
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-3:0] imem_addr;
  logic              imem_en;
  logic [31:0]       imem_rdata;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [31:0]       id_inst;
  logic [10:0]       id_opcode;
  logic [4:0]        id_rm;
  logic [4:0]        id_rn;
  logic [4:0]        id_rd;
  logic [8:0]        id_dt_addr;
  logic [15:0]       fetch_count;
  modport master (
    output stall, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, imem_en, id_valid, id_pc, id_inst, id_opcode, id_rm, id_rn, id_rd, id_dt_addr, fetch_count
  );
  modport slave (
    input  stall, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, imem_en, id_valid, id_pc, id_inst, id_opcode, id_rm, id_rn, id_rd, id_dt_addr, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, synchronous IMEM request and IF/ID register with field split
module fetch_stage #(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.slave bus
);
  logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d, id_pc_q, id_pc_d;
  logic              req_valid_q, req_valid_d, id_valid_q, id_valid_d;
  logic [31:0]       id_inst_q, id_inst_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              adv;
  // next state: redirect beats stall, stall freezes everything, otherwise advance
  always_comb begin
    adv         = !bus.stall && !bus.redirect_valid;
    pc_d        = bus.redirect_valid ? bus.redirect_pc : adv ? pc_q + ADDR_W'(4) : pc_q;
    req_pc_d    = adv ? pc_q : req_pc_q;
    req_valid_d = bus.redirect_valid ? 1'b0 : adv ? 1'b1 : req_valid_q;
    id_valid_d  = bus.redirect_valid ? 1'b0 : adv ? req_valid_q : id_valid_q;
    id_pc_d     = adv ? req_pc_q : id_pc_q;
    id_inst_d   = adv ? bus.imem_rdata : id_inst_q;
    cnt_d       = cnt_q + 16'(adv && req_valid_q);
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= ADDR_W'(RESET_PC);
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      id_valid_q  <= 1'b0;
      id_pc_q     <= '0;
      id_inst_q   <= '0;
      cnt_q       <= '0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      id_valid_q  <= id_valid_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
      cnt_q       <= cnt_d;
    end
  end
  // IMEM is only read when the request register will capture the result
  assign bus.imem_addr   = pc_q[ADDR_W-1:2];
  assign bus.imem_en     = !bus.stall || bus.redirect_valid;
  assign bus.id_valid    = id_valid_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_inst     = id_inst_q;
  assign bus.fetch_count = cnt_q;
  // bubbles decode as all-zero fields
  assign bus.id_opcode   = id_valid_q ? id_inst_q[31:21] : '0;
  assign bus.id_rm       = id_valid_q ? id_inst_q[20:16] : '0;
  assign bus.id_rn       = id_valid_q ? id_inst_q[9:5]   : '0;
  assign bus.id_rd       = id_valid_q ? id_inst_q[4:0]   : '0;
  assign bus.id_dt_addr  = id_valid_q ? id_inst_q[20:12] : '0;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: reference-model and directed checks of fetch_stage
module tb_fetch_stage;
  logic clk = 0;
  logic rst = 1;
  logic go = 0;
  int errors = 0;
  int checks = 0;
  logic [31:0] mem [64];
  fetch_if #(.ADDR_W(8)) bus ();
  fetch_stage #(.ADDR_W(8), .RESET_PC(0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
  int m_pc = 0;
  int m_req = -1;
  logic m_valid = 0;
  int m_idpc = 0;
  logic [31:0] m_inst = 0;
  logic [15:0] m_cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_pc = 0; m_req = -1; m_valid = 0; m_idpc = 0; m_inst = 0; m_cnt = 0;
    end else if (bus.redirect_valid) begin
      m_pc = int'(bus.redirect_pc); m_req = -1; m_valid = 0;
    end else if (!bus.stall) begin
      m_valid = (m_req >= 0);
      if (m_valid) begin
        m_idpc = m_req;
        m_inst = mem[m_req / 4];
        m_cnt = m_cnt + 16'd1;
      end
      m_req = m_pc;
      m_pc = (m_pc + 4) % 256;
    end
  end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  always @(negedge clk) if (go) begin
    chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc / 4));
    chk("imem_en", 32'(bus.imem_en), 32'(!bus.stall || bus.redirect_valid));
    chk("id_valid", 32'(bus.id_valid), 32'(m_valid));
    chk("fetch_count", 32'(bus.fetch_count), 32'(m_cnt));
    if (m_valid) begin
      chk("id_pc", 32'(bus.id_pc), 32'(m_idpc));
      chk("id_inst", bus.id_inst, m_inst);
      chk("id_opcode", 32'(bus.id_opcode), 32'(m_inst >> 21));
      chk("id_rm", 32'(bus.id_rm), (m_inst >> 16) & 32'h1F);
      chk("id_rn", 32'(bus.id_rn), (m_inst >> 5) & 32'h1F);
      chk("id_rd", 32'(bus.id_rd), m_inst & 32'h1F);
      chk("id_dt_addr", 32'(bus.id_dt_addr), (m_inst >> 12) & 32'h1FF);
    end else begin
      chk("bubble_fields", {bus.id_opcode, bus.id_rm, bus.id_rn, bus.id_rd}, 32'h0);
      chk("bubble_dt", 32'(bus.id_dt_addr), 32'h0);
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic redir(input logic [7:0] t, input logic st);
    bus.redirect_valid = 1; bus.redirect_pc = t; bus.stall = st;
    step(1);
    bus.redirect_valid = 0; bus.stall = 0;
    chk("redir_b1", 32'(bus.id_valid), 0);
    chk("redir_b1_op", 32'(bus.id_opcode), 0);
    step(1);
    chk("redir_b2", 32'(bus.id_valid), 0);
    chk("redir_b2_op", 32'(bus.id_opcode), 0);
    step(1);
    chk("redir_t", {31'(bus.id_pc), bus.id_valid}, {31'(t), 1'b1});
    step(1);
    chk("redir_t4", 32'(bus.id_pc), 32'(t + 8'd4));
  endtask
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h8B000000 | i;
    mem[20] = 32'hF8400000 | (32'h1F3 << 12) | (32'd7 << 5) | 32'd3;
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0; bus.imem_rdata = 0;
    step(2);
    go = 1;
    rst = 0;
    chk("c0_valid", 32'(bus.id_valid), 0);
    step(1);
    chk("c1_valid", 32'(bus.id_valid), 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("seq_pc", 32'(bus.id_pc), 32'(4 * i));
      chk("seq_rd", 32'(bus.id_inst[4:0]), 32'(i));
    end
    chk("seq_count", 32'(bus.fetch_count), 3);
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("stall_pc", 32'(bus.id_pc), 8);
      chk("stall_cnt", 32'(bus.fetch_count), 3);
    end
    bus.stall = 0;
    step(1);
    chk("post_stall_pc", 32'(bus.id_pc), 12);
    chk("post_stall_cnt", 32'(bus.fetch_count), 4);
    redir(8'h40, 0);
    redir(8'h48, 1);
    step(1);
    chk("ldur_op", 32'(bus.id_opcode), 32'h7C2);
    chk("ldur_dt", 32'(bus.id_dt_addr), 32'h1F3);
    chk("ldur_rn", 32'(bus.id_rn), 7);
    chk("ldur_rd", 32'(bus.id_rd), 3);
    redir(8'hF0, 0);
    step(2);
    chk("wrap_fc", 32'(bus.id_pc), 32'hFC);
    step(1);
    chk("wrap_00", {31'(bus.id_pc), bus.id_valid}, 32'h1);
    bus.stall = 1; rst = 1;
    step(1);
    rst = 0; bus.stall = 0;
    chk("rst_out", {bus.id_inst[30:0], bus.id_valid}, 0);
    chk("rst_pc_cnt", {bus.id_pc, bus.fetch_count}, 0);
    chk("rst_op", 32'(bus.id_opcode), 0);
    step(2);
    chk("restart", {31'(bus.id_pc), bus.id_valid}, 32'h1);
    rst = 1;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    step(1);
    rst = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.stall = ($urandom_range(0, 99) < 20);
      bus.redirect_valid = ($urandom_range(0, 99) < 8);
      bus.redirect_pc = 8'($urandom) & 8'hFC;
      rst = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst = 0; bus.stall = 0; bus.redirect_valid = 0;
    step(1);
    go = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
